vga_frame_monitor: RTL

//   Synthesizable VGA output monitor, successor to the simulation-only frame capture path.

---
 rtl/vga_frame_monitor.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vga_frame_monitor.sv
// VGA output monitor: locks onto vs, checks line and frame periods and CRC-16s the
// sampled {r,g,b} stream, reporting one result set per frame for N_FRAMES frames.
module vga_frame_monitor #(
  parameter int COLOR_W  = 4,
  parameter int H_TOTAL  = 1344,
  parameter int V_TOTAL  = 806,
  parameter bit SYNC_POL = 1'b1,
  parameter int N_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               hs,
  input  logic               vs,
  input  logic [COLOR_W-1:0] r,
  input  logic [COLOR_W-1:0] g,
  input  logic [COLOR_W-1:0] b,
  output logic               frame_valid,
  output logic [15:0]        frame_crc,
  output logic               frame_h_ok,
  output logic               frame_v_ok,
  output logic [11:0]        line_count,
  output logic [7:0]         frame_count,
  output logic               done,
  output logic               error
);

  localparam int DW = 3 * COLOR_W;
  localparam int SW = $clog2(H_TOTAL * V_TOTAL) + 2;
  localparam int PW = $clog2(H_TOTAL) + 2;
  localparam logic [SW-1:0] FRAME_SAMPLES = SW'(H_TOTAL * V_TOTAL);
  localparam logic [PW-1:0] LINE_CLKS     = PW'(H_TOTAL);
  localparam logic [11:0]   FRAME_LINES   = 12'(V_TOTAL);
  localparam logic [8:0]    LAST_FRAME    = 9'(N_FRAMES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // CRC-16-CCITT (poly 0x1021), one DW-bit word per call, MSB first
  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic [DW-1:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = DW - 1; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  state_t         state_r, state_next_s;
  logic           hs_q_r, vs_q_r;
  logic           hs_edge_s, vs_edge_s;
  logic [DW-1:0]  rgb_s;
  logic [15:0]    crc_r;
  logic [SW-1:0]  sample_cnt_r;
  logic [11:0]    line_cnt_r, line_total_s;
  logic [PW-1:0]  pix_cnt_r;
  logic           seen_hs_r, h_ok_r;
  logic           h_bad_s, h_fin_s, v_ok_s;
  logic           clear_s, close_s, last_frame_s;

  assign rgb_s        = {r, g, b};
  assign hs_edge_s    = (hs == SYNC_POL) && (hs_q_r != SYNC_POL);
  assign vs_edge_s    = (vs == SYNC_POL) && (vs_q_r != SYNC_POL);
  assign clear_s      = !enable || (state_r == IDLE);
  assign close_s      = enable && (state_r == CAPTURE) && vs_edge_s;
  assign last_frame_s = ({1'b0, frame_count} + 9'd1) == LAST_FRAME;
  // an hs edge coinciding with the closing vs edge still belongs to the closing frame
  assign h_bad_s      = hs_edge_s && seen_hs_r && (pix_cnt_r != LINE_CLKS);
  assign line_total_s = (hs_edge_s && (line_cnt_r != 12'hFFF)) ? line_cnt_r + 12'd1 : line_cnt_r;
  assign h_fin_s      = h_ok_r && !h_bad_s;
  assign v_ok_s       = (line_total_s == FRAME_LINES) && (sample_cnt_r == FRAME_SAMPLES);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // next-state logic; dropping enable aborts from any state
  always_comb begin
    state_next_s = state_r;
    if (!enable) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_next_s = SYNC;
        SYNC:    if (vs_edge_s) state_next_s = CAPTURE; else state_next_s = SYNC;
        CAPTURE: if (vs_edge_s && last_frame_s) state_next_s = DONE; else state_next_s = CAPTURE;
        DONE:    state_next_s = DONE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // sync history for leading-edge detection, parked at the deasserted level in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q_r <= ~SYNC_POL;
      vs_q_r <= ~SYNC_POL;
    end else begin
      hs_q_r <= hs;
      vs_q_r <= vs;
    end
  end

  // clocks since the last hs edge, saturating
  always_ff @(posedge clk) begin
    if (rst || clear_s)                 pix_cnt_r <= {PW{1'b0}};
    else if (hs_edge_s)                 pix_cnt_r <= PW'(1);
    else if (pix_cnt_r != {PW{1'b1}})   pix_cnt_r <= pix_cnt_r + PW'(1);
  end

  // per-frame accumulators; a vs edge cycle is sample 0 of the frame it opens
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      crc_r        <= 16'hFFFF;
      sample_cnt_r <= {SW{1'b0}};
      line_cnt_r   <= 12'd0;
      seen_hs_r    <= 1'b0;
      h_ok_r       <= 1'b1;
    end else if ((state_r == SYNC || state_r == CAPTURE) && vs_edge_s) begin
      crc_r        <= crc16_step(16'hFFFF, rgb_s);
      sample_cnt_r <= SW'(1);
      line_cnt_r   <= 12'd0;
      seen_hs_r    <= seen_hs_r || hs_edge_s;
      h_ok_r       <= 1'b1;
    end else if (state_r == CAPTURE) begin
      crc_r      <= crc16_step(crc_r, rgb_s);
      line_cnt_r <= line_total_s;
      if (sample_cnt_r != {SW{1'b1}}) sample_cnt_r <= sample_cnt_r + SW'(1);
      if (hs_edge_s) seen_hs_r <= 1'b1;
      if (h_bad_s)   h_ok_r    <= 1'b0;
    end
  end

  // frame results and run status
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid <= 1'b0;
      frame_crc   <= 16'h0000;
      frame_h_ok  <= 1'b0;
      frame_v_ok  <= 1'b0;
      line_count  <= 12'd0;
      frame_count <= 8'd0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      frame_valid <= close_s;
      if (clear_s) begin
        frame_count <= 8'd0;
        done        <= 1'b0;
        error       <= 1'b0;
      end else if (close_s) begin
        frame_crc   <= crc_r;
        frame_h_ok  <= h_fin_s;
        frame_v_ok  <= v_ok_s;
        line_count  <= line_total_s;
        if (frame_count != 8'hFF) frame_count <= frame_count + 8'd1;
        error       <= error || !(h_fin_s && v_ok_s);
        done        <= last_frame_s;
      end
    end
  end

endmodule
